button_debounce: RTL and testbench
==================================

# button_debounce

Multi-channel push-button conditioner that sits directly upstream of the AND/OR logic and LED stage. It takes the raw, asynchronous, bouncing button pins and produces clean, synchronized, debounced levels to drive that stage's `and_in1`, `and_in2`, `or_in1` and `or_in2` inputs. It also produces one-cycle press and release pulses and a long-press pulse for later control logic. Each channel is fully independent.

## Interface
- `N_CH`, default 4: number of button channels.
- `DEBOUNCE_CYCLES`, default 12000: number of consecutive stable clock cycles required to accept a new level. Must be ≥ 1.
- `LONG_CYCLES`, default 1200000: number of clock cycles a debounced press must be held before `btn_long` fires. Must be ≥ 1.
- `ACTIVE_LOW`, default 1: when 1, the raw pin is inverted so that a pin at 0 means pressed.
- `clk`  in  1  system clock. The single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `btn_raw`  in  N_CH  raw button pins, asynchronous to `clk`.
- `btn_level`  out  N_CH  debounced level; 1 = pressed.
- `btn_rise`  out  N_CH  one-cycle pulse on each accepted press.
- `btn_fall`  out  N_CH  one-cycle pulse on each accepted release.
- `btn_long`  out  N_CH  one-cycle pulse when a press has been held for `LONG_CYCLES` cycles.

## Operation
- **Input conditioning:** `p = btn_raw ^ {N_CH{ACTIVE_LOW}}`, so `p = 1` means pressed.
- **Synchronizer:** each channel has two flops, `s1 <= p` then `s2 <= s1`. Only `s2` is used downstream.
- **Per-channel debounce state:** `stable` (drives `btn_level`) and `cnt`, which is `clog2(DEBOUNCE_CYCLES+1)` bits wide.
- **Debounce update, evaluated every rising edge:**
  - If `s2 == stable`: `cnt <= 0`. Any single-cycle agreement fully restarts the count (glitch rejection).
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`. On the same edge, `btn_rise <= s2` and `btn_fall <= ~s2`.
  - Else: `cnt <= cnt + 1`.
- **Edge pulses:** `btn_rise` and `btn_fall` are registered, are 0 on every edge that does not flip `stable`, and are never both 1 in the same cycle.
- **Long press:** each channel has a `hold` counter, `clog2(LONG_CYCLES+1)` bits wide.
  - `hold <= 0` while `stable == 0`, and on the edge where `stable` rises.
  - While `stable == 1`, `hold` increments by 1 per edge and saturates at `LONG_CYCLES`.
  - `btn_long` is 1 for exactly the one cycle following the edge on which `hold` becomes `LONG_CYCLES`.
  - There is at most one `btn_long` per press. No repeat firing while held.
- **Release during hold:** a release accepted before `hold` reaches `LONG_CYCLES` cancels the long press; no `btn_long` is produced for that press.
- **Channel independence:** simultaneous activity on different channels is handled with no interaction.

## Timing
- **Reset values (`rst_n = 0`, asynchronous):**
  - `s1`, `s2`, `stable` = 0, i.e. released after inversion.
  - `cnt` and `hold` = 0.
  - `btn_level`, `btn_rise`, `btn_fall`, `btn_long` = 0.
- **Post-reset idle:** a button held idle through reset produces no pulse after reset release.
- **Reset mid-operation:** reset during a debounce count or a held press drops `btn_level` to 0 immediately, with no `btn_fall` pulse. If the button is still pressed after release, it is re-detected after the full latency.
- **Accept latency:** count the edge at which `s1` first samples the new value as edge 1. `btn_level` and the matching `btn_rise`/`btn_fall` update on edge `DEBOUNCE_CYCLES+2`.
  - Requirement: the raw value must stay constant from edge 1 until the change is accepted.
- **Long-press latency:** `btn_long` asserts on edge `LONG_CYCLES` after the edge on which `btn_level` rose.
- **Bounce rejection:** a raw change whose synchronized value reverts after fewer than `DEBOUNCE_CYCLES` cycles produces no output change.
- **Counter limits:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **`DEBOUNCE_CYCLES = 1`:** a change is accepted on the first mismatching edge, giving a latency of 3 edges.

## Test plan
All scenarios use `N_CH=4`, `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=10`, `ACTIVE_LOW=1`.
1. **Reset:** `btn_raw = 4'hF` with reset asserted then released → all outputs 0 and stay 0 for 50 cycles.
2. **Clean press:** ch0 raw 1→0, synchronous to the clock → `btn_level[0]` and a `btn_rise[0]` pulse occur on edge 6; `btn_long[0]` pulses 10 edges later; ch1–3 are unaffected.
3. **Bounce:** ch1 raw toggles 0/1 every 2 cycles for 20 cycles, then holds 0 → exactly one `btn_rise[1]`, 6 edges after the final toggle; no other pulses.
4. **Short press:** ch2 pressed for 8 cycles, then released → `btn_rise[2]`, then `btn_fall[2]` 8 edges later; no `btn_long[2]`.
5. **Simultaneous:** all channels pressed on the same edge → all four `btn_rise` bits pulse on the same cycle.
6. **Reset while held:** reset asserted while ch3 is held after acceptance → `btn_level[3]` drops asynchronously with no `btn_fall`. After release with the pin still low, `btn_rise[3]` fires again 6 edges later.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Per-channel synchronizer and debouncer for raw push buttons, with
//            press/release pulses and a single long-press pulse per press.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LONG_CYCLES     = 1200000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long
);

    localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HW = $clog2(LONG_CYCLES + 1);

    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HOLD_MAX  = c_HW'(LONG_CYCLES);
    localparam logic [c_HW-1:0] c_HOLD_FIRE = c_HW'(LONG_CYCLES - 1);

    logic [N_CH-1:0] w_pressed;

    assign w_pressed = btn_raw ^ {N_CH{ACTIVE_LOW}};

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic            r_s1;
            logic            r_s2;
            logic            r_stable;
            logic            r_rise;
            logic            r_fall;
            logic            r_long;
            logic [c_CW-1:0] r_cnt;
            logic [c_HW-1:0] r_hold;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_stable <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_long   <= 1'b0;
                    r_cnt    <= '0;
                    r_hold   <= '0;
                end else begin
                    r_s1   <= w_pressed[i];
                    r_s2   <= r_s1;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;

                    // Any agreement with the accepted level restarts the count.
                    if (r_s2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                        r_rise   <= r_s2;
                        r_fall   <= ~r_s2;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end

                    // Hold saturates, so the long pulse can fire only once per press.
                    if (!r_stable) begin
                        r_hold <= '0;
                    end else if (r_hold != c_HOLD_MAX) begin
                        r_hold <= r_hold + c_HW'(1);
                    end
                    r_long <= r_stable && (r_hold == c_HOLD_FIRE);
                end
            end

            assign btn_level[i] = r_stable;
            assign btn_rise[i]  = r_rise;
            assign btn_fall[i]  = r_fall;
            assign btn_long[i]  = r_long;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Directed self-checking bench for button_debounce (4 ch, 4/10 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;
    logic [3:0] btn_long;

    int n_checks = 0;
    int n_errors = 0;

    int rise_n [4] = '{default: 0};
    int fall_n [4] = '{default: 0};
    int long_n [4] = '{default: 0};

    button_debounce #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_long  (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rise_n[i] = rise_n[i] + int'(btn_rise[i]);
            fall_n[i] = fall_n[i] + int'(btn_fall[i]);
            long_n[i] = long_n[i] + int'(btn_long[i]);
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. Reset with all buttons idle (pins high)
        rst_n   = 1'b0;
        btn_raw = 4'hF;
        step(3);
        chk4("rst_level", btn_level, 4'h0);
        chk4("rst_rise",  btn_rise,  4'h0);
        chk4("rst_fall",  btn_fall,  4'h0);
        chk4("rst_long",  btn_long,  4'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step(1);
            chk4("idle_quiet", btn_level | btn_rise | btn_fall | btn_long, 4'h0);
        end

        // 2. Clean press on ch0: accept on edge 6, long on edge 16
        btn_raw[0] = 1'b0;
        step(5);
        chk4("press0_e5_level", btn_level, 4'h0);
        step(1);
        chk4("press0_e6_level", btn_level, 4'h1);
        chk4("press0_e6_rise",  btn_rise,  4'h1);
        step(1);
        chk4("press0_e7_rise",  btn_rise,  4'h0);
        step(8);
        chk4("press0_e15_long", btn_long,  4'h0);
        step(1);
        chk4("press0_e16_long", btn_long,  4'h1);
        step(1);
        chk4("press0_e17_long", btn_long,  4'h0);
        step(15);
        chk_int("press0_long_once", long_n[0], 1);
        btn_raw[0] = 1'b1;
        step(6);
        chk4("rel0_fall",  btn_fall,  4'h1);
        chk4("rel0_level", btn_level, 4'h0);
        step(4);

        // 3. Bounce on ch1, then settle pressed
        for (int ph = 0; ph < 10; ph++) begin
            btn_raw[1] = ph[0];
            step(2);
            chk4("bounce_level", btn_level, 4'h0);
        end
        btn_raw[1] = 1'b0;
        step(5);
        chk4("bounce_e5_level", btn_level, 4'h0);
        chk_int("bounce_no_early_rise", rise_n[1], 0);
        step(1);
        chk4("bounce_e6_rise",  btn_rise,  4'h2);
        chk4("bounce_e6_level", btn_level, 4'h2);
        btn_raw[1] = 1'b1;
        step(14);
        chk4("bounce_released", btn_level, 4'h0);

        // 4. Short press on ch2: released before long press matures
        btn_raw[2] = 1'b0;
        step(6);
        chk4("short2_rise", btn_rise, 4'h4);
        step(2);
        btn_raw[2] = 1'b1;
        step(5);
        chk4("short2_e13_level", btn_level, 4'h4);
        chk4("short2_e13_fall",  btn_fall,  4'h0);
        step(1);
        chk4("short2_e14_fall",  btn_fall,  4'h4);
        chk4("short2_e14_level", btn_level, 4'h0);
        step(12);
        chk_int("short2_no_long", long_n[2], 0);

        // 5. All channels pressed on the same edge
        btn_raw = 4'h0;
        step(5);
        chk4("simul_e5_rise", btn_rise, 4'h0);
        step(1);
        chk4("simul_e6_rise",  btn_rise,  4'hF);
        chk4("simul_e6_level", btn_level, 4'hF);
        chk4("simul_e6_fall",  btn_fall,  4'h0);
        step(2);

        // 6. Asynchronous reset while held, pins stay low
        #2;
        rst_n = 1'b0;
        #1;
        chk4("rst_held_level", btn_level, 4'h0);
        chk4("rst_held_fall",  btn_fall,  4'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk4("redet_e5_level", btn_level, 4'h0);
        chk4("redet_e5_fall",  btn_fall,  4'h0);
        step(1);
        chk4("redet_e6_rise",  btn_rise,  4'hF);
        chk4("redet_e6_level", btn_level, 4'hF);
        step(1);

        // Cumulative pulse totals across the whole run
        chk_int("tot_rise0", rise_n[0], 3);
        chk_int("tot_rise1", rise_n[1], 3);
        chk_int("tot_rise2", rise_n[2], 3);
        chk_int("tot_rise3", rise_n[3], 2);
        chk_int("tot_fall0", fall_n[0], 1);
        chk_int("tot_fall1", fall_n[1], 1);
        chk_int("tot_fall2", fall_n[2], 1);
        chk_int("tot_fall3", fall_n[3], 0);
        chk_int("tot_long0", long_n[0], 1);
        chk_int("tot_long1", long_n[1], 0);
        chk_int("tot_long2", long_n[2], 0);
        chk_int("tot_long3", long_n[3], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
